atomic_unit: RTL

- RV32A atomic execution unit in the MEM stage: executes LR.W, SC.W and the AMO*.W ops as multi-cycle read-modify-write sequences on the data-memory port.
- Owns the LR/SC reservation register.
- Produces atomic_unit_stall, which the hazard handler and pipeline-enable logic consume. atomic_unit_stall low while is_atomic_mem is high marks the cycle the result is valid and forwardable.

---
 rtl/atomic_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/atomic_unit.sv
// RV32A atomic execution unit for the MEM stage: LR.W, SC.W and AMO*.W as
// multi-cycle read-modify-write sequences, plus the LR/SC reservation.
module atomic_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              is_atomic_mem,
    input  logic [4:0]        amo_funct5_mem,
    input  logic [ADDR_W-1:0] addr_mem,
    input  logic [XLEN-1:0]   rs2_data_mem,
    input  logic              mem_write_mem,
    output logic              atomic_unit_stall,
    output logic [XLEN-1:0]   atomic_result,
    output logic              amo_misaligned,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_ack
);

    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_SWAP = 5'b00001;
    localparam logic [4:0] F_LR   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00011;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_OR   = 5'b01000;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000;
    localparam logic [4:0] F_MAXU = 5'b11100;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t              state_q;
    logic [ADDR_W-3:0]   wordAddr_q;
    logic [ADDR_W-3:0]   resAddr_q;
    logic                resValid_q;
    logic [4:0]          funct_q;
    logic [XLEN-1:0]     rs2_q;
    logic [XLEN-1:0]     old_q;
    logic [XLEN-1:0]     result_q;
    logic [XLEN-1:0]     wdata_q;
    logic                req_q;
    logic                we_q;
    logic                misaligned_q;
    logic [XLEN-1:0]     newVal_d;
    logic                resMatch;

    assign resMatch          = resValid_q && (addr_mem[ADDR_W-1:2] == resAddr_q);
    assign atomic_unit_stall = is_atomic_mem && (state_q != DONE);

    assign atomic_result  = result_q;
    assign amo_misaligned = misaligned_q;
    assign dmem_req       = req_q;
    assign dmem_we        = we_q;
    assign dmem_addr      = {wordAddr_q, 2'b00};
    assign dmem_wdata     = wdata_q;

    // Equal operands fall through to the old value for all min/max flavours.
    always_comb begin
        newVal_d = rs2_q;
        case (funct_q)
            F_ADD:   newVal_d = dmem_rdata + rs2_q;
            F_XOR:   newVal_d = dmem_rdata ^ rs2_q;
            F_AND:   newVal_d = dmem_rdata & rs2_q;
            F_OR:    newVal_d = dmem_rdata | rs2_q;
            F_MIN:   newVal_d = ($signed(rs2_q) < $signed(dmem_rdata)) ? rs2_q : dmem_rdata;
            F_MAX:   newVal_d = ($signed(rs2_q) > $signed(dmem_rdata)) ? rs2_q : dmem_rdata;
            F_MINU:  newVal_d = (rs2_q < dmem_rdata) ? rs2_q : dmem_rdata;
            F_MAXU:  newVal_d = (rs2_q > dmem_rdata) ? rs2_q : dmem_rdata;
            F_SWAP:  newVal_d = rs2_q;
            default: newVal_d = rs2_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wordAddr_q   <= '0;
            resAddr_q    <= '0;
            resValid_q   <= 1'b0;
            funct_q      <= '0;
            rs2_q        <= '0;
            old_q        <= '0;
            result_q     <= '0;
            wdata_q      <= '0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= 1'b0;
            // Snoop first so that an LR set later in this block takes priority.
            if (mem_write_mem && resMatch) begin
                resValid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (is_atomic_mem) begin
                        funct_q    <= amo_funct5_mem;
                        wordAddr_q <= addr_mem[ADDR_W-1:2];
                        rs2_q      <= rs2_data_mem;
                        if (addr_mem[1:0] != 2'b00) begin
                            state_q      <= DONE;
                            misaligned_q <= 1'b1;
                            result_q     <= '0;
                        end else if (amo_funct5_mem == F_SC) begin
                            resValid_q <= 1'b0;
                            if (resMatch) begin
                                state_q <= WRITE;
                                req_q   <= 1'b1;
                                we_q    <= 1'b1;
                                wdata_q <= rs2_data_mem;
                            end else begin
                                state_q  <= DONE;
                                result_q <= XLEN'(1);
                            end
                        end else begin
                            state_q <= READ;
                            req_q   <= 1'b1;
                            we_q    <= 1'b0;
                        end
                    end
                end
                READ: begin
                    if (dmem_ack) begin
                        old_q <= dmem_rdata;
                        if (funct_q == F_LR) begin
                            resValid_q <= 1'b1;
                            resAddr_q  <= wordAddr_q;
                            result_q   <= dmem_rdata;
                            req_q      <= 1'b0;
                            state_q    <= DONE;
                        end else begin
                            wdata_q <= newVal_d;
                            we_q    <= 1'b1;
                            state_q <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (dmem_ack) begin
                        req_q    <= 1'b0;
                        we_q     <= 1'b0;
                        result_q <= (funct_q == F_SC) ? '0 : old_q;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
